// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I controller:
// ALU operation codes, FSM states, opcodes and datapath mux selects.
package ctrl_pkg;

    localparam int ALUCTRL_W = 4;
    localparam int FLAG_W    = 4;

    // ALU operation codes as understood by the ALU
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_XOR   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_SRA   = 4'd10,
        ALU_LUI   = 4'd11,
        ALU_AUIPC = 4'd12
    } alu_op_t;

    // Coarse ALU operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUCLS_ADD   = 2'd0,
        ALUCLS_SUB   = 2'd1,
        ALUCLS_FUNCT = 2'd2,
        ALUCLS_UPPER = 2'd3
    } alu_class_t;

    // Controller states, one per cycle
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_UPPER    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Datapath mux selects
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [2:0] IMM_I         = 3'b000;
    localparam logic [2:0] IMM_S         = 3'b001;
    localparam logic [2:0] IMM_B         = 3'b010;
    localparam logic [2:0] IMM_J         = 3'b011;
    localparam logic [2:0] IMM_U         = 3'b100;

    // Branch condition from funct3 and the SUB flags {N,Z,C,V}; C=1 means A>=B unsigned
    function automatic logic branch_taken(input logic [2:0] f3, input logic [FLAG_W-1:0] flags);
        logic taken;
        case (f3)
            3'b000:  taken = flags[2];
            3'b001:  taken = ~flags[2];
            3'b100:  taken = flags[3] ^ flags[0];
            3'b101:  taken = ~(flags[3] ^ flags[0]);
            3'b110:  taken = ~flags[1];
            3'b111:  taken = flags[1];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALU class plus instruction
// fields into the 4-bit ALUControl code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0]           alu_class,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    // Map class and funct fields to an ALU op; op5 separates R-type from I-type and lui from auipc
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            ALUCLS_ADD:   alu_control = ALU_ADD;
            ALUCLS_SUB:   alu_control = ALU_SUB;
            ALUCLS_UPPER: alu_control = op5 ? ALU_LUI : ALU_AUIPC;
            ALUCLS_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences each instruction through its
// states and decodes mux selects, write enables and the ALU op from state.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic [FLAG_W-1:0]    Flags,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal
);

    state_t      state_r;
    state_t      next_state_s;
    logic        pc_write_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic [1:0]  alu_class_s;

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; unsupported opcodes and branch funct3 010/011 go to TRAP
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
                    OP_RTYPE:          next_state_s = S_EXECR;
                    OP_ITYPE:          next_state_s = S_EXECI;
                    OP_BRANCH:         next_state_s = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            next_state_s = S_JAL;
                    OP_LUI, OP_AUIPC:  next_state_s = S_UPPER;
                    default:           next_state_s = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state_s = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_EXECR:    next_state_s = S_ALUWB;
            S_EXECI:    next_state_s = S_ALUWB;
            S_UPPER:    next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            S_JAL:      next_state_s = S_ALUWB;
            S_TRAP:     next_state_s = S_TRAP;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Output decode from state (branch PCWrite additionally looks at the live flags)
    always_comb begin
        pc_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ImmSrc      = IMM_I;
        alu_class_s = ALUCLS_ADD;
        illegal     = 1'b0;
        case (state_r)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA     = SRCA_RD1;
                ALUSrcB     = SRCB_RD2;
                alu_class_s = ALUCLS_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA     = SRCA_RD1;
                ALUSrcB     = SRCB_IMM;
                alu_class_s = ALUCLS_FUNCT;
            end
            S_UPPER: begin
                ALUSrcA     = op[5] ? SRCA_RD1 : SRCA_OLDPC;
                ALUSrcB     = SRCB_IMM;
                ImmSrc      = IMM_U;
                alu_class_s = ALUCLS_UPPER;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_RD1;
                ALUSrcB     = SRCB_RD2;
                alu_class_s = ALUCLS_SUB;
                pc_write_s  = branch_taken(funct3, Flags);
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    // No architectural write may happen in a cycle where reset is asserted
    assign PCWrite  = pc_write_s  & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign IRWrite  = ir_write_s  & ~reset;
    assign RegWrite = reg_write_s & ~reset;

    alu_decoder u_alu_decoder (
        .alu_class   (alu_class_s),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: expected per-cycle control
// vectors are queued for each instruction and compared as the FSM steps.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] Flags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic [18:0] obs;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Flags(Flags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .illegal(illegal)
    );

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack one cycle's expected control outputs
    function automatic logic [31:0] ov(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic ill);
        return {13'd0, pcw, adr, mw, irw, rw, rs, a, b, imm, alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] v_fetch();
        return ov(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'd0, 1'b0);
    endfunction
    function automatic logic [31:0] v_decode();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b010, 4'd0, 1'b0);
    endfunction
    function automatic logic [31:0] v_aluwb();
        return ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0);
    endfunction

    task automatic push_fd();
        sb.push_back(v_fetch());
        sb.push_back(v_decode());
    endtask

    // Apply instruction fields and compare one queued vector per cycle
    task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [3:0] fl, input int n);
        logic [31:0] e;
        op = o; funct3 = f3; funct7b5 = f7; Flags = fl;
        for (int i = 0; i < n; i++) begin
            #1;
            e = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
            chk($sformatf("%s_c%0d", name, i + 1), {13'd0, obs}, e);
            @(negedge clk);
        end
    endtask

    // One-cycle reset pulse starting at a negedge; ends at a negedge in FETCH
    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #1;
        chk({name, "_rst_pcw"}, {31'd0, PCWrite}, 32'd0);
        chk({name, "_rst_mw"}, {31'd0, MemWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({name, "_post_fetch"}, {13'd0, obs}, v_fetch());
        chk({name, "_post_ill"}, {31'd0, illegal}, 32'd0);
    endtask

    // R/I ALU table: opcode, funct3, funct7b5, expected ALUControl
    logic [6:0] t_op [8];
    logic [2:0] t_f3 [8];
    logic       t_f7 [8];
    logic [3:0] t_alu[8];

    // Branch table: funct3, flags, taken
    logic [2:0] b_f3 [6];
    logic [3:0] b_fl [6];
    logic       b_tk [6];

    initial begin
        t_op[0] = 7'b0110011; t_f3[0] = 3'b000; t_f7[0] = 1'b1; t_alu[0] = 4'd1;
        t_op[1] = 7'b0110011; t_f3[1] = 3'b000; t_f7[1] = 1'b0; t_alu[1] = 4'd0;
        t_op[2] = 7'b0010011; t_f3[2] = 3'b000; t_f7[2] = 1'b1; t_alu[2] = 4'd0;
        t_op[3] = 7'b0110011; t_f3[3] = 3'b101; t_f7[3] = 1'b1; t_alu[3] = 4'd10;
        t_op[4] = 7'b0010011; t_f3[4] = 3'b101; t_f7[4] = 1'b0; t_alu[4] = 4'd7;
        t_op[5] = 7'b0110011; t_f3[5] = 3'b100; t_f7[5] = 1'b0; t_alu[5] = 4'd8;
        t_op[6] = 7'b0010011; t_f3[6] = 3'b011; t_f7[6] = 1'b0; t_alu[6] = 4'd9;
        t_op[7] = 7'b0110011; t_f3[7] = 3'b111; t_f7[7] = 1'b0; t_alu[7] = 4'd2;

        b_f3[0] = 3'b000; b_fl[0] = 4'b0100; b_tk[0] = 1'b1;
        b_f3[1] = 3'b000; b_fl[1] = 4'b0000; b_tk[1] = 1'b0;
        b_f3[2] = 3'b100; b_fl[2] = 4'b1000; b_tk[2] = 1'b1;
        b_f3[3] = 3'b101; b_fl[3] = 4'b1001; b_tk[3] = 1'b1;
        b_f3[4] = 3'b110; b_fl[4] = 4'b0010; b_tk[4] = 1'b0;
        b_f3[5] = 3'b111; b_fl[5] = 4'b0010; b_tk[5] = 1'b1;

        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Flags = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_pcw", {31'd0, PCWrite}, 32'd0);
        chk("reset_irw", {31'd0, IRWrite}, 32'd0);
        chk("reset_ill", {31'd0, illegal}, 32'd0);
        chk("reset_srcb", {30'd0, ALUSrcB}, 32'd2);
        reset = 1'b0;

        // lw: five cycles, RegWrite only in the last
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'd0, 1'b0));
        sb.push_back(ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0));
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0));
        run("lw", 7'b0000011, 3'b010, 1'b0, 4'd0, 5);

        // R/I ALU ops
        for (int i = 0; i < 8; i++) begin
            push_fd();
            if (t_op[i][5])
                sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, t_alu[i], 1'b0));
            else
                sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, t_alu[i], 1'b0));
            sb.push_back(v_aluwb());
            run($sformatf("alu%0d", i), t_op[i], t_f3[i], t_f7[i], 4'd0, 4);
        end

        // Branches: three cycles, PCWrite in BRANCH follows the condition
        for (int i = 0; i < 6; i++) begin
            push_fd();
            sb.push_back(ov(b_tk[i], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd1, 1'b0));
            run($sformatf("br%0d", i), 7'b1100011, b_f3[i], 1'b0, b_fl[i], 3);
        end

        // lui then auipc
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b100, 4'd11, 1'b0));
        sb.push_back(v_aluwb());
        run("lui", 7'b0110111, 3'b000, 1'b0, 4'd0, 4);
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b100, 4'd12, 1'b0));
        sb.push_back(v_aluwb());
        run("auipc", 7'b0010111, 3'b000, 1'b0, 4'd0, 4);

        // jal
        push_fd();
        sb.push_back(ov(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 4'd0, 1'b0));
        sb.push_back(v_aluwb());
        run("jal", 7'b1101111, 3'b000, 1'b0, 4'd0, 4);

        // sw: four cycles
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 1'b0));
        sb.push_back(ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0));
        run("sw", 7'b0100011, 3'b010, 1'b0, 4'd0, 4);

        // sw aborted by reset while in MEMWRITE
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'd0, 1'b0));
        run("swabort", 7'b0100011, 3'b010, 1'b0, 4'd0, 3);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("abort_vec", {13'd0, obs}, ov(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_fetch_irw", {31'd0, IRWrite}, 32'd1);
        chk("abort_fetch_vec", {13'd0, obs}, v_fetch());

        // Branch with reserved funct3 ends in TRAP without redirecting the PC
        push_fd();
        run("brbad", 7'b1100011, 3'b010, 1'b0, 4'b0100, 2);
        #1;
        chk("brbad_c3_pcw", {31'd0, PCWrite}, 32'd0);
        @(negedge clk);
        #1;
        chk("brbad_c4_ill", {31'd0, illegal}, 32'd1);
        chk("brbad_c4_pcw", {31'd0, PCWrite}, 32'd0);
        @(negedge clk);
        pulse_reset("brbad");

        // Unknown opcode: TRAP held for 20 cycles, cleared by reset
        push_fd();
        for (int i = 0; i < 20; i++)
            sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'd0, 1'b1));
        run("trap", 7'b1111111, 3'b000, 1'b0, 4'd0, 22);
        pulse_reset("trap");

        // Normal instruction after recovery
        push_fd();
        sb.push_back(ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'd3, 1'b0));
        sb.push_back(v_aluwb());
        run("or_after", 7'b0110011, 3'b110, 1'b0, 4'd0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
